vc_pipe_reg_chain: RTL and testbench

- Parametrised, elastic chain of pipeline registers with per-stage valid bits and a val/rdy handshake on both sides.
- Successor to the single-stage enable/reset registers: depth and width are configurable, stalls are supported, and bubbles collapse.
- Used to retime long datapaths and to add latency-insensitive delay between val/rdy units.

---
 rtl/vc_pipe_reg_chain.sv | 155 +++++++++++++++
 tb/tb_vc_pipe_reg_chain.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vc_pipe_reg_chain.sv
// Elastic val/rdy register chain with per-stage valid bits and bubble collapsing.
// Optional synchronous flush port enabled by defining VC_PIPE_REG_CHAIN_FLUSH_EN.
module vc_pipe_reg_chain #(
  parameter int unsigned          p_nbits       = 8,
  parameter int unsigned          p_nstages     = 3,
  parameter logic [p_nbits-1:0]   p_reset_value = '0
) (
  input  logic                             clk,
  input  logic                             reset,
`ifdef VC_PIPE_REG_CHAIN_FLUSH_EN
  input  logic                             flush,
`endif
  input  logic                             in_val,
  output logic                             in_rdy,
  input  logic [p_nbits-1:0]               in_msg,
  output logic                             out_val,
  input  logic                             out_rdy,
  output logic [p_nbits-1:0]               out_msg,
  output logic [$clog2(p_nstages+1)-1:0]   occupancy
);

  localparam int unsigned OCC_W = $clog2(p_nstages + 1);
  localparam int          LAST  = int'(p_nstages) - 1;

  logic [p_nstages-1:0] val_q;
  logic [p_nstages-1:0] val_d;
  logic [p_nstages-1:0] go_s;
  logic [p_nstages-1:0] load_s;
  logic [p_nbits-1:0]   data_q [p_nstages];
  logic [p_nbits-1:0]   data_d [p_nstages];
  logic [OCC_W-1:0]     occ_q;
  logic [OCC_W-1:0]     occ_d;
  logic                 flush_s;
  logic                 down_ok_s;
  logic                 in_xfer_s;

`ifdef VC_PIPE_REG_CHAIN_FLUSH_EN
  assign flush_s = flush;
`else
  assign flush_s = 1'b0;
`endif

  function automatic logic [OCC_W-1:0] popcount(input logic [p_nstages-1:0] v);
    logic [OCC_W-1:0] cnt;
    cnt = '0;
    for (int k = 0; k < int'(p_nstages); k++) begin
      cnt = cnt + OCC_W'(v[k]);
    end
    return cnt;
  endfunction

  // Advance chain: a stage may move when the stage below is empty or moving too.
  // This intentionally ripples out_rdy all the way to in_rdy in one cycle.
  always_comb begin
    go_s      = '0;
    down_ok_s = out_rdy & ~flush_s;
    for (int k = LAST; k >= 0; k--) begin
      go_s[k]   = val_q[k] & down_ok_s;
      down_ok_s = ~val_q[k] | go_s[k];
    end
  end

  assign in_rdy    = ~reset & ~flush_s & down_ok_s;
  assign in_xfer_s = in_val & in_rdy;

  // Next-state for valid bits, data registers and occupancy count
  always_comb begin
    load_s    = '0;
    load_s[0] = in_xfer_s;
    for (int k = 1; k < int'(p_nstages); k++) begin
      load_s[k] = go_s[k-1];
    end

    val_d  = val_q;
    data_d = data_q;
    for (int k = 0; k < int'(p_nstages); k++) begin
      if (flush_s) begin
        val_d[k] = 1'b0;
      end else if (load_s[k]) begin
        val_d[k] = 1'b1;
      end else if (go_s[k]) begin
        val_d[k] = 1'b0;
      end else begin
        val_d[k] = val_q[k];
      end
    end

    if (load_s[0]) begin
      data_d[0] = in_msg;
    end else begin
      data_d[0] = data_q[0];
    end
    for (int k = 1; k < int'(p_nstages); k++) begin
      if (load_s[k]) begin
        data_d[k] = data_q[k-1];
      end else begin
        data_d[k] = data_q[k];
      end
    end

    occ_d = popcount(val_d);
  end

  // Stage state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      val_q <= '0;
      occ_q <= '0;
      for (int k = 0; k < int'(p_nstages); k++) begin
        data_q[k] <= p_reset_value;
      end
    end else begin
      val_q  <= val_d;
      data_q <= data_d;
      occ_q  <= occ_d;
    end
  end

  assign out_val   = val_q[LAST] & ~flush_s;
  assign out_msg   = data_q[LAST];
  assign occupancy = occ_q;

  vc_pipe_reg_chain_checker #(
    .p_nbits (p_nbits)
  ) u_checker (
    .clk     (clk),
    .reset   (reset),
    .in_val  (in_val),
    .in_msg  (in_msg),
    .out_rdy (out_rdy)
  );

endmodule

// Simulation-only protocol checks on the chain inputs.
module vc_pipe_reg_chain_checker #(
  parameter int unsigned p_nbits = 8
) (
  input logic               clk,
  input logic               reset,
  input logic               in_val,
  input logic [p_nbits-1:0] in_msg,
  input logic               out_rdy
);

  a_in_val_known: assert property (@(posedge clk) disable iff (reset)
    !$isunknown(in_val));

  a_out_rdy_known: assert property (@(posedge clk) disable iff (reset)
    !$isunknown(out_rdy));

  a_in_msg_known: assert property (@(posedge clk) disable iff (reset)
    in_val |-> !$isunknown(in_msg));

endmodule

// File: tb/tb_vc_pipe_reg_chain.sv
// Scoreboard bench for vc_pipe_reg_chain (3 stages, 8 bits); the flush
// scenario is built only when VC_PIPE_REG_CHAIN_FLUSH_EN is defined.
module tb_vc_pipe_reg_chain;

  typedef struct {
    logic [7:0] msg;
    int         cyc;
  } exp_t;

  logic       clk;
  logic       reset;
  logic       in_val;
  logic       in_rdy;
  logic [7:0] in_msg;
  logic       out_val;
  logic       out_rdy;
  logic [7:0] out_msg;
  logic [1:0] occupancy;
`ifdef VC_PIPE_REG_CHAIN_FLUSH_EN
  logic       flush;
`endif

  exp_t sb[$];
  exp_t mon_e;
  int   cyc;
  int   vectors;
  int   miscompares;
  int   acc;
  int   t0;

  vc_pipe_reg_chain #(
    .p_nbits       (8),
    .p_nstages     (3),
    .p_reset_value (8'h00)
  ) dut (
    .clk       (clk),
    .reset     (reset),
`ifdef VC_PIPE_REG_CHAIN_FLUSH_EN
    .flush     (flush),
`endif
    .in_val    (in_val),
    .in_rdy    (in_rdy),
    .in_msg    (in_msg),
    .out_val   (out_val),
    .out_rdy   (out_rdy),
    .out_msg   (out_msg),
    .occupancy (occupancy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Monitor: every output transfer must match the head of the scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && out_val && out_rdy) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", int'(out_msg), -1);
        end else begin
          mon_e = sb.pop_front();
          chk("out_msg", int'(out_msg), int'(mon_e.msg));
          chk("out_cycle", cyc, mon_e.cyc);
        end
      end
    end
  end

  initial begin
    cyc         = 0;
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    in_val      = 1'b0;
    in_msg      = 8'h00;
    out_rdy     = 1'b0;
`ifdef VC_PIPE_REG_CHAIN_FLUSH_EN
    flush       = 1'b0;
`endif

    // Reset
    step();
    step();
    settle();
    chk("rst_in_rdy", in_rdy, 0);
    reset = 1'b0;
    settle();
    chk("rst_out_val", out_val, 0);
    chk("rst_out_msg", out_msg, 8'h00);
    chk("rst_occ", occupancy, 0);
    chk("rst_in_rdy_after", in_rdy, 1);

    // Single message: latency of 3 cycles
    out_rdy = 1'b1;
    in_val  = 1'b1;
    in_msg  = 8'hA5;
    settle();
    t0 = cyc;
    sb.push_back('{8'hA5, t0 + 3});
    step();
    in_val = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      settle();
      chk("single_occ", occupancy, (i <= 3) ? 1 : 0);
      chk("single_out_val", out_val, (i == 3) ? 1 : 0);
      step();
    end

    // Streaming at full rate
    settle();
    t0 = cyc;
    for (int i = 0; i < 8; i++) begin
      in_val = 1'b1;
      in_msg = 8'(i + 1);
      settle();
      chk("stream_in_rdy", in_rdy, 1);
      sb.push_back('{8'(i + 1), t0 + i + 3});
      step();
    end
    in_val = 1'b0;
    repeat (5) step();

    // Backpressure fill, then drain while accepting one more
    out_rdy = 1'b0;
    acc     = 0;
    for (int c = 0; c < 5; c++) begin
      in_val = 1'b1;
      in_msg = 8'(8'h31 + acc);
      settle();
      chk("fill_in_rdy", in_rdy, (c < 3) ? 1 : 0);
      if (in_rdy) acc++;
      step();
    end
    settle();
    chk("fill_accepted", acc, 3);
    chk("fill_occ", occupancy, 3);
    t0      = cyc;
    out_rdy = 1'b1;
    in_msg  = 8'h34;
    settle();
    chk("drain_in_rdy", in_rdy, 1);
    sb.push_back('{8'h31, t0});
    sb.push_back('{8'h32, t0 + 1});
    sb.push_back('{8'h33, t0 + 2});
    sb.push_back('{8'h34, t0 + 3});
    step();
    in_val = 1'b0;
    settle();
    chk("full_pass_occ", occupancy, 3);
    repeat (4) step();
    chk("drain_occ", occupancy, 0);

    // Bubble collapse under out_rdy=0
    out_rdy = 1'b0;
    in_val  = 1'b1;
    in_msg  = 8'h11;
    step();
    in_val = 1'b0;
    step();
    in_val = 1'b1;
    in_msg = 8'h22;
    step();
    in_val = 1'b0;
    step();
    settle();
    chk("bubble_occ", occupancy, 2);
    chk("bubble_in_rdy", in_rdy, 1);
    chk("bubble_out_val", out_val, 1);
    chk("bubble_out_msg", out_msg, 8'h11);
    t0      = cyc;
    out_rdy = 1'b1;
    sb.push_back('{8'h11, t0});
    sb.push_back('{8'h22, t0 + 1});
    repeat (4) step();
    chk("bubble_drain_occ", occupancy, 0);

    // Reset mid-operation discards contents
    out_rdy = 1'b0;
    in_val  = 1'b1;
    in_msg  = 8'h41;
    step();
    in_msg = 8'h42;
    step();
    in_val = 1'b0;
    settle();
    chk("midrst_pre_occ", occupancy, 2);
    reset  = 1'b1;
    in_val = 1'b1;
    in_msg = 8'h43;
    settle();
    chk("midrst_in_rdy", in_rdy, 0);
    step();
    reset  = 1'b0;
    in_val = 1'b0;
    settle();
    chk("midrst_out_val", out_val, 0);
    chk("midrst_occ", occupancy, 0);
    chk("midrst_out_msg", out_msg, 8'h00);
    chk("midrst_in_rdy_after", in_rdy, 1);
    out_rdy = 1'b1;
    repeat (4) step();

`ifdef VC_PIPE_REG_CHAIN_FLUSH_EN
    // Flush clears a full chain without any transfer
    out_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_val = 1'b1;
      in_msg = 8'(8'h51 + i);
      step();
    end
    in_val = 1'b0;
    settle();
    chk("flush_pre_occ", occupancy, 3);
    flush   = 1'b1;
    in_val  = 1'b1;
    in_msg  = 8'h59;
    out_rdy = 1'b1;
    settle();
    chk("flush_in_rdy", in_rdy, 0);
    chk("flush_out_val", out_val, 0);
    step();
    flush  = 1'b0;
    in_val = 1'b0;
    settle();
    chk("flush_occ", occupancy, 0);
    chk("flush_out_val_after", out_val, 0);
    in_val = 1'b1;
    in_msg = 8'h5A;
    settle();
    t0 = cyc;
    sb.push_back('{8'h5A, t0 + 3});
    step();
    in_val = 1'b0;
    repeat (4) step();
`endif

    repeat (3) step();
    chk("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
